// File: rtl/display_scan_if.sv
// Bundle between the application and the display scan controller.
// Ports: iEn, iLoad, iData, iMask (toward scanner); oCode, oAn, oBlank, oFrame (back).
interface display_scan_if #(
    parameter int DIGITS = 8
) ();
    logic                  iEn;
    logic                  iLoad;
    logic [4*DIGITS-1:0]   iData;
    logic [DIGITS-1:0]     iMask;
    logic [3:0]            oCode;
    logic [DIGITS-1:0]     oAn;
    logic                  oBlank;
    logic                  oFrame;

    modport master (
        output iEn, iLoad, iData, iMask,
        input  oCode, oAn, oBlank, oFrame
    );

    modport slave (
        input  iEn, iLoad, iData, iMask,
        output oCode, oAn, oBlank, oFrame
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered codes.
// Ports: clk, rst (sync, active-high), bus (slave side of display_scan_if).
module display_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic           clk,
    input  logic           rst,
    display_scan_if.slave  bus
);
    localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(DIGITS);
    localparam int DW   = 4 * DIGITS;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    // With no blanking interval every digit starts directly in SHOW.
    localparam state_t S_FIRST = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_shadow;
    logic [DW-1:0]   r_active;
    logic            r_pending;
    logic [3:0]      r_code;
    logic [DIGITS-1:0] r_an;
    logic            r_blank;
    logic            r_frame;

    state_t          w_state_nx;
    logic [IW-1:0]   w_idx_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic            w_bound;
    logic            w_entry;
    logic [DW-1:0]   w_shadow_nx;
    logic [DW-1:0]   w_active_nx;
    logic            w_pending_nx;
    logic [DIGITS-1:0] w_onehot;
    logic            w_lit;
    logic [3:0]      w_code_nx;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_bound    = 1'b0;
        w_entry    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_idx_nx = '0;
                w_cnt_nx = '0;
                if (bus.iEn) begin
                    w_state_nx = S_FIRST;
                    w_entry    = 1'b1;
                end
            end
            S_BLANK: begin
                if (!bus.iEn) begin
                    w_state_nx = S_IDLE;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                end else if (r_cnt == BLANK_LAST) begin
                    w_state_nx = S_SHOW;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_SHOW: begin
                if (!bus.iEn) begin
                    w_state_nx = S_IDLE;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                end else if (r_cnt == SHOW_LAST) begin
                    w_state_nx = S_FIRST;
                    w_cnt_nx   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nx = '0;
                        w_bound  = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // A load coinciding with a transfer point goes straight to active.
    always_comb begin
        w_shadow_nx  = r_shadow;
        w_active_nx  = r_active;
        w_pending_nx = r_pending;
        if (bus.iLoad) begin
            w_shadow_nx  = bus.iData;
            w_pending_nx = 1'b1;
        end
        if (w_bound || w_entry) begin
            if (bus.iLoad) begin
                w_active_nx = bus.iData;
            end else if (r_pending) begin
                w_active_nx = r_shadow;
            end
            w_pending_nx = 1'b0;
        end
    end

    // Outputs are registered from next-state values so they line up
    // with the state they describe.
    assign w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << w_idx_nx;
    assign w_lit    = (w_state_nx == S_SHOW) && bus.iMask[w_idx_nx];
    assign w_code_nx = (w_state_nx == S_IDLE) ? 4'd0
                     : w_active_nx[{w_idx_nx, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_an      <= '1;
            r_code    <= 4'd0;
            r_blank   <= 1'b1;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_cnt     <= w_cnt_nx;
            r_shadow  <= w_shadow_nx;
            r_active  <= w_active_nx;
            r_pending <= w_pending_nx;
            r_an      <= w_lit ? ~w_onehot : '1;
            r_code    <= w_code_nx;
            r_blank   <= ~w_lit;
            r_frame   <= w_bound;
        end
    end

    assign bus.oCode  = r_code;
    assign bus.oAn    = r_an;
    assign bus.oBlank = r_blank;
    assign bus.oFrame = r_frame;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model,
// directed steps followed by a randomized run.
module tb_display_scan_ctrl;
    localparam int DIGITS = 8;
    localparam int SDIV   = 4;
    localparam int BLK    = 2;
    localparam int SLOT   = SDIV + BLK;
    localparam int FRAME  = DIGITS * SLOT;

    logic clk = 1'b0;
    logic rst;

    display_scan_if #(.DIGITS(DIGITS)) bus ();

    display_scan_ctrl #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SDIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: scanning position counted from frame start.
    bit          m_on;
    int          m_pos;
    logic [31:0] m_act;
    logic [31:0] m_sh;
    bit          m_pend;
    logic [3:0]  e_code;
    logic [7:0]  e_an;
    logic        e_blank;
    logic        e_frame;

    task automatic model_step();
        bit          xfer;
        bit          old_p;
        logic [31:0] old_sh;
        int          d;
        bit          lit;
        xfer    = 0;
        e_frame = 1'b0;
        old_p   = m_pend;
        old_sh  = m_sh;
        if (rst) begin
            m_on   = 0;
            m_pos  = 0;
            m_act  = '0;
            m_sh   = '0;
            m_pend = 0;
        end else begin
            if (!m_on) begin
                if (bus.iEn) begin
                    m_on  = 1;
                    m_pos = 0;
                    xfer  = 1;
                end
            end else if (!bus.iEn) begin
                m_on = 0;
            end else begin
                if (m_pos == FRAME - 1) begin
                    xfer    = 1;
                    e_frame = 1'b1;
                end
                m_pos = (m_pos + 1) % FRAME;
            end
            if (bus.iLoad) begin
                m_sh   = bus.iData;
                m_pend = 1;
            end
            if (xfer) begin
                if (bus.iLoad) m_act = bus.iData;
                else if (old_p) m_act = old_sh;
                m_pend = 0;
            end
        end
        if (!m_on) begin
            e_an    = 8'hFF;
            e_blank = 1'b1;
            e_code  = 4'd0;
        end else begin
            d       = m_pos / SLOT;
            lit     = ((m_pos % SLOT) >= BLK) && bus.iMask[d];
            e_code  = 4'((m_act >> (4 * d)) & 32'hF);
            e_an    = lit ? ~(8'(1) << d) : 8'hFF;
            e_blank = ~lit;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0t: got %h want %h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("oAn", 32'(bus.oAn), 32'(e_an));
        chk("oBlank", 32'(bus.oBlank), 32'(e_blank));
        chk("oCode", 32'(bus.oCode), 32'(e_code));
        chk("oFrame", 32'(bus.oFrame), 32'(e_frame));
        chk("an_onehot", 32'($countones(~bus.oAn) <= 1), 32'd1);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(logic [31:0] d);
        bus.iLoad = 1'b1;
        bus.iData = d;
        tick();
        bus.iLoad = 1'b0;
    endtask

    // Advance until the model says the current cycle is at frame position p.
    task automatic wait_pos(int p);
        int n;
        n = 0;
        while (!(m_on && m_pos == p) && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (m_on && m_pos == p) else begin
            n_bad++;
            $error("FAIL wait_pos: got pos %0d want %0d", m_pos, p);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.iEn   = 1'b0;
        bus.iLoad = 1'b0;
        bus.iData = '0;
        bus.iMask = 8'hFF;
        m_on = 0; m_pos = 0; m_act = '0; m_sh = '0; m_pend = 0;

        // Reset, then enable: 2 blank cycles, then digit 0.
        run(2);
        rst = 1'b0;
        bus.iEn = 1'b1;
        run(6);

        // Scan order and frame pulse.
        load(32'h76543210);
        run(2 * FRAME);

        // Odd digits only.
        bus.iMask = 8'b1010_1010;
        run(FRAME);
        bus.iMask = 8'hFF;

        // Load mid-frame: later digits keep old codes until the boundary.
        wait_pos(3 * SLOT + BLK);
        load(32'h99999999);
        run(FRAME + 8);

        // Load sampled on the boundary edge itself.
        wait_pos(FRAME - 1);
        load($urandom);
        run(FRAME);

        // Enable drop during SHOW of digit 5, then re-enable.
        wait_pos(5 * SLOT + BLK + 1);
        bus.iEn = 1'b0;
        run(4);
        load(32'hA5A5_5A5A);
        run(2);
        bus.iEn = 1'b1;
        run(FRAME + 4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.iEn   = ($urandom_range(0, 99) < 97);
            bus.iLoad = ($urandom_range(0, 99) < 6);
            bus.iData = $urandom;
            if ($urandom_range(0, 19) == 0) bus.iMask = 8'($urandom);
            tick();
        end
        bus.iLoad = 1'b0;
        bus.iEn   = 1'b1;
        bus.iMask = 8'hFF;

        // Reset with a pending load in flight.
        wait_pos(4);
        load(32'hFEDC_BA98);
        wait_pos(SLOT + BLK);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(SLOT * 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
